hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the port list is as follows.
REQ-002 i_clk  in  1  rising-edge clock.
REQ-003 i_rst  in  1  synchronous active-low reset.
REQ-004 insn_vld_d  in  1  the decode-stage instruction is valid.
REQ-005 rs1_addr_d, rs2_addr_d  in  5 each  decode-stage source register indices.
REQ-006 rs1_use_d, rs2_use_d  in  1 each  the decode-stage instruction reads rs1 / rs2.
REQ-007 rd_addr_d  in  5  decode-stage destination register index.
REQ-008 rd_wren_d  in  1  the decode-stage instruction writes rd.
REQ-009 br_taken_e  in  1  a branch or jump resolved in EX redirects the PC.
REQ-010 stall_f  out  1  hold the PC.
REQ-011 stall_d  out  1  hold the IF/ID register.
REQ-012 flush_d  out  1  clear the IF/ID register.
REQ-013 flush_e  out  1  load a bubble into the ID/EX register.
REQ-014 stall_cnt  out  32  count of stalled cycles.

Function
REQ-015 The block SHALL keep a shadow pipeline of three slots: E, M and W. Each slot holds {rd[4:0], wr_vld}.
REQ-016 Every cycle the slots SHALL advance: W<=M, M<=E.
- E <= {0,0} when flush_e=1.
- Otherwise E <= {rd_addr_d, insn_vld_d & rd_wren_d & (rd_addr_d!=0)}.
REQ-017 A hazard exists when all of the following hold:
- insn_vld_d=1;
- for some source X with use=1 and addr!=0, a slot S in the active set has wr_vld=1 and rd==addr X.
REQ-018 The active set SHALL be {E,M,W}; see REQ-029 for the configured alternative.
REQ-019 Outputs SHALL be combinational from the current inputs and slot state, with zero-cycle latency:
- stall_f = stall_d = hazard & ~br_taken_e;
- flush_d = br_taken_e;
- flush_e = br_taken_e | hazard.
REQ-020 A taken branch SHALL take priority over a hazard: stalls are suppressed in that cycle and both registers are flushed.
REQ-021 During a stall, the stalled decode instruction SHALL be re-evaluated each cycle. The stall releases in the first cycle in which no active-set match remains.
REQ-022 A stall SHALL last at most 3 cycles, or 2 cycles with RF_WR_BYPASS_EN.
REQ-023 x0 SHALL never cause a hazard and SHALL never be recorded as a pending write.
REQ-024 stall_cnt SHALL increment by 1 on each clock edge where stall_d=1. It saturates at 0xFFFF_FFFF and never wraps.
REQ-025 When rs1 and rs2 match different slots, the hazard SHALL persist until the youngest match retires from the active set.

Reset
REQ-026 While i_rst=0 at a rising edge, the block SHALL clear all slots to {0,0} and set stall_cnt to 0.
REQ-027 While i_rst=0, all 1-bit outputs SHALL be 0, regardless of the other inputs.
REQ-028 Reset asserted mid-stall SHALL abandon the stall. The first cycle after release SHALL show no hazard.

Configuration
REQ-029 RF_WR_BYPASS_EN selects register-file behaviour:
- Defined: the register file is write-before-read, slot W is excluded from the active set (active set = {E,M}), and W-slot state still advances.
- Undefined: the active set is {E,M,W}.

Structure
REQ-030 A shared package SHALL hold:
- the slot typedef {logic [4:0] rd; logic wr_vld};
- constant REG_ZERO = 5'd0;
- constant STALL_CNT_W = 32.
REQ-031 One sub-module, hazard_slot_cmp, SHALL compare one source address against one slot. It is instantiated six times (2 sources × 3 slots).

Verification
REQ-032 ADD x5 then immediately ADD x6,x5,x1 (no bypass) -> stall_d=1 for exactly 3 cycles, flush_e=1 in those same cycles, stall_cnt=3.
REQ-033 Same sequence with RF_WR_BYPASS_EN -> stall_d=1 for exactly 2 cycles, stall_cnt=2.
REQ-034 Writer to x0, then a reader of x0 -> stall_d=0, flush_e=0 in every cycle.
REQ-035 A hazard pending and br_taken_e=1 in the same cycle -> stall_f=stall_d=0, flush_d=flush_e=1, slot E invalid on the next cycle.
REQ-036 Stall in progress, then i_rst=0 for 1 cycle -> all outputs 0, stall_cnt=0; after release, an unrelated instruction in decode shows no stall.
REQ-037 stall_cnt preloaded at 0xFFFF_FFFE via force, then 3 stall cycles -> stall_cnt = 0xFFFF_FFFF, held.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared types and constants for the hazard controller.
// Holds the shadow-pipeline slot type, the x0 register index, the stall
// counter width and a helper that qualifies a source operand.
package hazard_ctrl_pkg;

   typedef struct packed {
      logic [4:0] rd;
      logic       wr_vld;
   } slot_t;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         STALL_CNT_W = 32;

   localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

   // A source can only create a hazard when it is actually read and is not x0.
   function automatic logic src_active(input logic rd_en, input logic [4:0] addr);
      return rd_en & (addr != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_slot_cmp.sv
// hazard_slot_cmp -- compares one decode-stage source operand against one
// shadow-pipeline slot; asserts match when the slot holds a pending write
// to the register being read.
module hazard_slot_cmp
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] src_addr,
   input  logic       src_en,
   input  logic [4:0] slot_rd,
   input  logic       slot_vld,
   output logic       match
);

   assign match = src_active(src_en, src_addr) & slot_vld & (slot_rd == src_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- RAW hazard detection and branch flush control for a
// 5-stage pipeline. A three-slot shadow pipeline (E, M, W) tracks pending
// register writes; a decode instruction reading a pending destination is
// stalled until the write leaves the active set.
// Optional feature macro: RF_WR_BYPASS_EN (write-before-read register file,
// slot W removed from the active set).
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   insn_vld_d,
   input  logic [4:0]             rs1_addr_d,
   input  logic [4:0]             rs2_addr_d,
   input  logic                   rs1_use_d,
   input  logic                   rs2_use_d,
   input  logic [4:0]             rd_addr_d,
   input  logic                   rd_wren_d,
   input  logic                   br_taken_e,
   output logic                   stall_f,
   output logic                   stall_d,
   output logic                   flush_d,
   output logic                   flush_e,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   // Bit 0 = E, bit 1 = M, bit 2 = W.
`ifdef RF_WR_BYPASS_EN
   localparam logic [2:0] ACTIVE_MASK = 3'b011;
`else
   localparam logic [2:0] ACTIVE_MASK = 3'b111;
`endif

   slot_t                  slot_e_r;
   slot_t                  slot_m_r;
   slot_t                  slot_w_r;
   slot_t                  slot_e_nxt_s;
   logic [STALL_CNT_W-1:0] stall_cnt_r;
   logic [5:0]             match_s;
   logic                   hazard_s;
   logic [4:0]             src_addr_s [2];
   logic                   src_en_s   [2];
   slot_t                  slot_s     [3];

   assign src_addr_s[0] = rs1_addr_d;
   assign src_addr_s[1] = rs2_addr_d;
   assign src_en_s[0]   = rs1_use_d;
   assign src_en_s[1]   = rs2_use_d;
   assign slot_s[0]     = slot_e_r;
   assign slot_s[1]     = slot_m_r;
   assign slot_s[2]     = slot_w_r;

   for (genvar gs = 0; gs < 2; gs++) begin : g_src
      for (genvar gk = 0; gk < 3; gk++) begin : g_slot
         hazard_slot_cmp u_cmp (
            .src_addr (src_addr_s[gs]),
            .src_en   (src_en_s[gs]),
            .slot_rd  (slot_s[gk].rd),
            .slot_vld (slot_s[gk].wr_vld),
            .match    (match_s[gs*3 + gk])
         );
      end
   end

   assign hazard_s  = insn_vld_d & ((|(match_s[2:0] & ACTIVE_MASK)) |
                                    (|(match_s[5:3] & ACTIVE_MASK)));
   assign stall_cnt = stall_cnt_r;

   // Zero-latency control outputs; a taken branch overrides any stall, and reset forces all low.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (i_rst) begin
         stall_f = hazard_s & ~br_taken_e;
         stall_d = hazard_s & ~br_taken_e;
         flush_d = br_taken_e;
         flush_e = br_taken_e | hazard_s;
      end else begin
         stall_f = 1'b0;
         stall_d = 1'b0;
         flush_d = 1'b0;
         flush_e = 1'b0;
      end
   end

   // Entry for slot E: a bubble when EX is flushed, otherwise the decode write (never x0).
   always_comb begin
      slot_e_nxt_s = '{rd: 5'd0, wr_vld: 1'b0};
      if (flush_e) begin
         slot_e_nxt_s = '{rd: 5'd0, wr_vld: 1'b0};
      end else begin
         slot_e_nxt_s.rd     = rd_addr_d;
         slot_e_nxt_s.wr_vld = insn_vld_d & rd_wren_d & (rd_addr_d != REG_ZERO);
      end
   end

   // Shadow pipeline advances every cycle, including stalled ones.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         slot_e_r <= '{rd: 5'd0, wr_vld: 1'b0};
         slot_m_r <= '{rd: 5'd0, wr_vld: 1'b0};
         slot_w_r <= '{rd: 5'd0, wr_vld: 1'b0};
      end else begin
         slot_w_r <= slot_m_r;
         slot_m_r <= slot_e_r;
         slot_e_r <= slot_e_nxt_s;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (stall_d && (stall_cnt_r != STALL_CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl. A history of the
// destinations entering EX in recent cycles predicts every output each
// cycle; directed sequences pin the stall length, x0 handling, branch
// priority, reset abandonment and counter saturation with literal values.
module tb_hazard_ctrl;

`ifdef RF_WR_BYPASS_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 3;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        insn_vld_d;
   logic [4:0]  rs1_addr_d, rs2_addr_d, rd_addr_d;
   logic        rs1_use_d, rs2_use_d, rd_wren_d, br_taken_e;
   logic        stall_f, stall_d, flush_d, flush_e;
   logic [31:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Model: hist[k] = {valid, rd} of the write that entered EX k+1 edges ago.
   logic [5:0]  hist [3];
   logic [31:0] m_cnt;
   bit          known = 1'b0;

   // Last sampled DUT outputs, for directed literal checks.
   logic s_stall_f, s_stall_d, s_flush_d, s_flush_e;

   hazard_ctrl dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .insn_vld_d (insn_vld_d),
      .rs1_addr_d (rs1_addr_d),
      .rs2_addr_d (rs2_addr_d),
      .rs1_use_d  (rs1_use_d),
      .rs2_use_d  (rs2_use_d),
      .rd_addr_d  (rd_addr_d),
      .rd_wren_d  (rd_wren_d),
      .br_taken_e (br_taken_e),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .stall_cnt  (stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   function automatic bit m_hit(input logic [4:0] a);
      for (int k = 0; k < DEPTH; k++)
         if (hist[k][5] && hist[k][4:0] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_hazard();
      bit h1, h2;
      h1 = rs1_use_d && (rs1_addr_d != 5'd0) && m_hit(rs1_addr_d);
      h2 = rs2_use_d && (rs2_addr_d != 5'd0) && m_hit(rs2_addr_d);
      return insn_vld_d && (h1 || h2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input bit v, input logic [4:0] a1, input bit u1,
                      input logic [4:0] a2, input bit u2,
                      input logic [4:0] d, input bit w, input bit br);
      insn_vld_d = v;  rs1_addr_d = a1; rs1_use_d = u1;
      rs2_addr_d = a2; rs2_use_d = u2;  rd_addr_d = d;
      rd_wren_d  = w;  br_taken_e = br;
   endtask

   task automatic nop();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // One cycle: check all outputs against the model, then advance the model at the edge.
   task automatic cycle();
      bit hz, e_st, e_fd, e_fe;
      #1;
      hz   = m_hazard();
      e_st = i_rst && hz && !br_taken_e;
      e_fd = i_rst && br_taken_e;
      e_fe = i_rst && (br_taken_e || hz);
      s_stall_f = stall_f; s_stall_d = stall_d;
      s_flush_d = flush_d; s_flush_e = flush_e;
      if (known || !i_rst) begin
         chk("stall_f", {31'd0, stall_f}, {31'd0, e_st});
         chk("stall_d", {31'd0, stall_d}, {31'd0, e_st});
         chk("flush_d", {31'd0, flush_d}, {31'd0, e_fd});
         chk("flush_e", {31'd0, flush_e}, {31'd0, e_fe});
      end
      if (known) chk("stall_cnt", stall_cnt, m_cnt);
      @(posedge i_clk);
      if (!i_rst) begin
         for (int k = 0; k < 3; k++) hist[k] = 6'd0;
         m_cnt = 32'd0;
         known = 1'b1;
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         if (!e_fe && insn_vld_d && rd_wren_d && rd_addr_d != 5'd0)
            hist[0] = {1'b1, rd_addr_d};
         else
            hist[0] = 6'd0;
         if (e_st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst = 1'b0; nop(); cycle(); i_rst = 1'b1;
   endtask

   initial begin
      int n;
      i_rst = 1'b0;
      nop();
      cycle();
      cycle();
      i_rst = 1'b1;

      // ADD x5 then ADD x6,x5,x1: stall length and counter.
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
      drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (s_stall_d) n++;
         else break;
      end
      chk("raw_stall_len", n, DEPTH);
      nop(); cycle();
      chk("raw_stall_cnt", stall_cnt, DEPTH);

      // Writer to x0, then reader of x0.
      do_reset();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); cycle();
      drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0); cycle();
      chk("x0_stall_d", {31'd0, s_stall_d}, 32'd0);
      chk("x0_flush_e", {31'd0, s_flush_e}, 32'd0);

      // Hazard and taken branch together: branch wins, EX gets a bubble.
      do_reset();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); cycle();
      drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1); cycle();
      chk("br_stall_f", {31'd0, s_stall_f}, 32'd0);
      chk("br_stall_d", {31'd0, s_stall_d}, 32'd0);
      chk("br_flush_d", {31'd0, s_flush_d}, 32'd1);
      chk("br_flush_e", {31'd0, s_flush_e}, 32'd1);
      drv(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0); cycle();
      chk("br_bubble_e", {31'd0, s_stall_d}, 32'd0);

      // Reset in the middle of a stall.
      do_reset();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); cycle();
      chk("rst_pre_stall", {31'd0, s_stall_d}, 32'd1);
      i_rst = 1'b0; cycle();
      chk("rst_outs", {28'd0, s_stall_f, s_stall_d, s_flush_d, s_flush_e}, 32'd0);
      i_rst = 1'b1;
      drv(1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0); cycle();
      chk("rst_cnt", stall_cnt, 32'd0);
      chk("rst_no_stall", {31'd0, s_stall_d}, 32'd0);

      // Counter saturation from a preloaded value.
      do_reset();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
      force dut.stall_cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_r;
      m_cnt = 32'hFFFF_FFFE;
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (!s_stall_d) break;
      end
      nop(); cycle(); cycle();
      chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         i_rst = ($urandom_range(0, 39) != 0);
         drv($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
